// File: rtl/asynch_fifo_pkg.sv
// rtl/asynch_fifo_pkg.sv - gray-code helpers and address-width helper for the level-reporting async FIFO
// Contents:
//   GRAY_MAX_W  widest pointer the helpers handle; narrower pointers are zero-extended
//               on the way in and size-cast on the way out
//   ptr_addr_w  address bits needed for a given depth
//   bin2gray    binary to reflected gray code
//   gray2bin    reflected gray code to binary
package asynch_fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic int ptr_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended upper bits decode to zero, so the low bits of the result are
    // exact for any narrower pointer.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_gray_synch.sv
// rtl/cdc_gray_synch.sv - multi-flop synchroniser for a gray-coded pointer
// Parameters: WIDTH pointer width, SYNC_STAGES flops in the chain (>= 2)
// Ports:
//   clk       destination-domain clock
//   rst_low   asynchronous active-low reset, clears every stage
//   ptr_gray  registered gray pointer from the source domain
//   ptr_sync  pointer after SYNC_STAGES destination flops
module cdc_gray_synch #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_low,
    input  logic [WIDTH-1:0] ptr_gray,
    output logic [WIDTH-1:0] ptr_sync
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_low) begin
        if (!rst_low) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign ptr_sync = stage[SYNC_STAGES-1];

endmodule

// File: rtl/asynch_fifo_lvl.sv
// rtl/asynch_fifo_lvl.sv - dual-clock FWFT gray-pointer FIFO with fill levels, thresholds and sticky error flags
// Optional build macro: ASYNCH_FIFO_PARITY_EN (stores an even-parity bit per word, drives dst_parity_err_out)
// Ports:
//   src_clk_in / dst_clk_in       write / read clocks
//   rst_low_in                    asynchronous active-low reset for both domains
//   src_data_in, src_data_valid_in, src_fifo_ready_out   write interface (ready = not full)
//   src_level_out, src_almost_full_out                   src-side occupancy and threshold
//   src_overflow_out, src_clr_flags_in                   sticky write-while-full flag and its clear
//   dst_data_out, dst_data_valid_out, dst_ready_in       FWFT read interface (valid = not empty)
//   dst_level_out, dst_almost_empty_out                  dst-side occupancy and threshold
//   dst_underflow_out, dst_clr_flags_in                  sticky read-while-empty flag and its clear
//   dst_parity_err_out                                   parity error on head word (0 without the macro)
module asynch_fifo_lvl
    import asynch_fifo_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2,
    parameter int AE_MARGIN   = 1
) (
    input  logic                     src_clk_in,
    input  logic                     dst_clk_in,
    input  logic                     rst_low_in,
    input  logic [WIDTH-1:0]         src_data_in,
    input  logic                     src_data_valid_in,
    output logic                     src_fifo_ready_out,
    output logic [$clog2(DEPTH):0]   src_level_out,
    output logic                     src_almost_full_out,
    output logic                     src_overflow_out,
    input  logic                     src_clr_flags_in,
    output logic [WIDTH-1:0]         dst_data_out,
    output logic                     dst_data_valid_out,
    input  logic                     dst_ready_in,
    output logic [$clog2(DEPTH):0]   dst_level_out,
    output logic                     dst_almost_empty_out,
    output logic                     dst_underflow_out,
    input  logic                     dst_clr_flags_in,
    output logic                     dst_parity_err_out
);

    localparam int ADDR_W = ptr_addr_w(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);
    localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(AE_MARGIN);

`ifdef ASYNCH_FIFO_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif

    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] mem_wdata;
    logic [MEM_W-1:0] head;

    logic [PTR_W-1:0] wr_bin, wr_bin_next, wr_gray, wr_gray_next, wr_gray_sync;
    logic [PTR_W-1:0] rd_bin, rd_bin_next, rd_gray, rd_gray_next, rd_gray_sync;
    logic             full, empty, wr_en, rd_en;

    // ---------------- src domain ----------------
    assign full  = (wr_gray == {~rd_gray_sync[ADDR_W:ADDR_W-1], rd_gray_sync[ADDR_W-2:0]});
    assign wr_en = src_data_valid_in && !full;

    assign wr_bin_next  = wr_en ? wr_bin + PTR_W'(1) : wr_bin;
    assign wr_gray_next = PTR_W'(bin2gray(GRAY_MAX_W'(wr_bin_next)));

    always_ff @(posedge src_clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            wr_bin           <= '0;
            wr_gray          <= '0;
            src_overflow_out <= 1'b0;
        end else begin
            wr_bin  <= wr_bin_next;
            wr_gray <= wr_gray_next;
            // A new overflow in the same cycle as a clear must stay visible.
            if (src_data_valid_in && full) begin
                src_overflow_out <= 1'b1;
            end else if (src_clr_flags_in) begin
                src_overflow_out <= 1'b0;
            end
        end
    end

`ifdef ASYNCH_FIFO_PARITY_EN
    assign mem_wdata = {^src_data_in, src_data_in};
`else
    assign mem_wdata = src_data_in;
`endif

    // Storage is deliberately not reset; stale contents are masked by the pointers.
    always_ff @(posedge src_clk_in) begin
        if (wr_en) begin
            mem[wr_bin[ADDR_W-1:0]] <= mem_wdata;
        end
    end

    assign src_fifo_ready_out  = !full;
    assign src_level_out       = wr_bin - PTR_W'(gray2bin(GRAY_MAX_W'(rd_gray_sync)));
    assign src_almost_full_out = (src_level_out >= AF_LEVEL);

    // ---------------- dst domain ----------------
    assign empty = (wr_gray_sync == rd_gray);
    assign rd_en = dst_ready_in && !empty;

    assign rd_bin_next  = rd_en ? rd_bin + PTR_W'(1) : rd_bin;
    assign rd_gray_next = PTR_W'(bin2gray(GRAY_MAX_W'(rd_bin_next)));

    always_ff @(posedge dst_clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            rd_bin            <= '0;
            rd_gray           <= '0;
            dst_underflow_out <= 1'b0;
        end else begin
            rd_bin  <= rd_bin_next;
            rd_gray <= rd_gray_next;
            if (dst_ready_in && empty) begin
                dst_underflow_out <= 1'b1;
            end else if (dst_clr_flags_in) begin
                dst_underflow_out <= 1'b0;
            end
        end
    end

    assign head                 = mem[rd_bin[ADDR_W-1:0]];
    assign dst_data_out         = head[WIDTH-1:0];
    assign dst_data_valid_out   = !empty;
    assign dst_level_out        = PTR_W'(gray2bin(GRAY_MAX_W'(wr_gray_sync))) - rd_bin;
    assign dst_almost_empty_out = (dst_level_out <= AE_LEVEL);

`ifdef ASYNCH_FIFO_PARITY_EN
    assign dst_parity_err_out = dst_data_valid_out && (^head != 1'b0);
`else
    assign dst_parity_err_out = 1'b0;
`endif

    // ---------------- pointer crossings ----------------
    cdc_gray_synch #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr_to_dst (
        .clk      (dst_clk_in),
        .rst_low  (rst_low_in),
        .ptr_gray (wr_gray),
        .ptr_sync (wr_gray_sync)
    );

    cdc_gray_synch #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rd_to_src (
        .clk      (src_clk_in),
        .rst_low  (rst_low_in),
        .ptr_gray (rd_gray),
        .ptr_sync (rd_gray_sync)
    );

endmodule
